// File: rtl/aclk_controller_if.sv
// Signal bundle between the alarm-clock control FSM and the blocks around it:
// the keypad/buttons/timegen that feed it and the datapath it steers.
interface aclk_controller_if;
  logic       one_second;
  logic       key_pressed;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       shift;
  logic       load_new_a;
  logic       load_new_c;
  logic       show_new_time;
  logic       show_a;
  logic [2:0] digit_cnt;

  // master: the surrounding system (keypad, buttons, timegen, datapath)
  modport master (
    output one_second, key_pressed, key, alarm_button, time_button,
    input  shift, load_new_a, load_new_c, show_new_time, show_a, digit_cnt
  );

  // slave: the controller itself
  modport slave (
    input  one_second, key_pressed, key, alarm_button, time_button,
    output shift, load_new_a, load_new_c, show_new_time, show_a, digit_cnt
  );
endinterface

// File: rtl/aclk_controller.sv
// Alarm-clock main control FSM: sequences 4-digit keypad entry, abandons it
// after TIMEOUT_S idle seconds, and issues one-cycle load strobes.
module aclk_controller #(
  parameter int TIMEOUT_S = 10
) (
  input logic              clk,
  input logic              reset,
  aclk_controller_if.slave bus
);

  localparam logic [2:0] SHOW_TIME        = 3'd0;
  localparam logic [2:0] SHOW_ALARM       = 3'd1;
  localparam logic [2:0] KEY_STORED       = 3'd2;
  localparam logic [2:0] KEY_WAITED       = 3'd3;
  localparam logic [2:0] SET_ALARM_TIME   = 3'd4;
  localparam logic [2:0] SET_CURRENT_TIME = 3'd5;

  localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT_S - 1);

  logic [2:0] state;
  logic [2:0] digit_cnt;
  logic [3:0] timer;
  logic       digit_key;
  logic       entry_full;

  assign digit_key  = bus.key_pressed && (bus.key <= 4'd9);
  assign entry_full = (digit_cnt == 3'd4);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SHOW_TIME;
      digit_cnt <= 3'd0;
      timer     <= 4'd0;
    end else begin
      case (state)
        SHOW_TIME: begin
          if (bus.alarm_button) begin
            state <= SHOW_ALARM;
          end else if (digit_key) begin
            state     <= KEY_STORED;
            digit_cnt <= 3'd1;
            timer     <= 4'd0;
          end
        end
        SHOW_ALARM: begin
          if (!bus.alarm_button) state <= SHOW_TIME;
        end
        KEY_STORED: state <= KEY_WAITED;
        KEY_WAITED: begin
          // Time beats alarm, a commit beats a new key, a key beats timeout.
          if (bus.time_button && entry_full) begin
            state <= SET_CURRENT_TIME;
          end else if (bus.alarm_button && entry_full) begin
            state <= SET_ALARM_TIME;
          end else if (digit_key && !entry_full) begin
            state     <= KEY_STORED;
            digit_cnt <= digit_cnt + 3'd1;
            timer     <= 4'd0;
          end else if (bus.one_second) begin
            if (timer == TIMER_LAST) begin
              state     <= SHOW_TIME;
              digit_cnt <= 3'd0;
              timer     <= 4'd0;
            end else begin
              timer <= timer + 4'd1;
            end
          end
        end
        SET_ALARM_TIME, SET_CURRENT_TIME: begin
          state     <= SHOW_TIME;
          digit_cnt <= 3'd0;
          timer     <= 4'd0;
        end
        default: begin
          state     <= SHOW_TIME;
          digit_cnt <= 3'd0;
          timer     <= 4'd0;
        end
      endcase
    end
  end

  logic shift_d, load_a_d, load_c_d, show_new_d, show_a_d;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    shift_d    = 1'b0;
    load_a_d   = 1'b0;
    load_c_d   = 1'b0;
    show_new_d = 1'b0;
    show_a_d   = 1'b0;
    case (state)
      SHOW_ALARM:       show_a_d = 1'b1;
      KEY_STORED: begin
        shift_d    = 1'b1;
        show_new_d = 1'b1;
      end
      KEY_WAITED:       show_new_d = 1'b1;
      SET_ALARM_TIME:   load_a_d   = 1'b1;
      SET_CURRENT_TIME: load_c_d   = 1'b1;
      default: ;
    endcase
  end

  assign bus.shift         = shift_d;
  assign bus.load_new_a    = load_a_d;
  assign bus.load_new_c    = load_c_d;
  assign bus.show_new_time = show_new_d;
  assign bus.show_a        = show_a_d;
  assign bus.digit_cnt     = digit_cnt;

endmodule
